// File: rtl/ram_arb_pkg.sv
// Shared types, reset constants and width helper for the RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    localparam arb_state_t ARB_STATE_RST = UNLOCKED;
    localparam logic       RSP_VALID_RST = 1'b0;

    // Width of an index into n requesters (owner / round-robin pointer).
    function automatic int unsigned RAM_ARB_IDX_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arbiter_picker.sv
// rr_picker: one-hot selector that searches the request vector circularly from start.
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(start) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter with lock support for atomic sequences.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (lowest index wins).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MEM_DEPTH  = 32,
    parameter  int unsigned NUM_REQ    = 2,
    localparam int unsigned AW         = $clog2(MEM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic [DATA_WIDTH-1:0]         mem_read_data
);

    localparam int unsigned IW = RAM_ARB_IDX_W(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      owner, owner_nxt;
    logic [IW-1:0]      start;
    logic [IW-1:0]      gidx;
    logic [NUM_REQ-1:0] eligible, grant, rsp_q;
    logic               xfer;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr, ptr_nxt;
    assign start = ptr;
`else
    assign start = '0;
`endif

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req   (eligible),
        .start (start),
        .grant (grant)
    );

    // While locked only the owner's valid reaches the picker.
    always_comb begin
        eligible = req_valid;
        if (state == LOCKED) begin
            eligible        = '0;
            eligible[owner] = req_valid[owner];
        end
    end

    always_comb begin
        gidx           = '0;
        mem_we         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx           = IW'(i);
                mem_we         = req_we[i];
                mem_address    = req_addr[i*AW +: AW];
                mem_write_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer      = |grant;
    assign req_ready = grant;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        ptr_nxt   = ptr;
`endif
        case (state)
            UNLOCKED: begin
                if (xfer) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    ptr_nxt = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
`endif
                    if (req_lock[gidx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = gidx;
                    end
                end
            end
            LOCKED: begin
                if (xfer && !req_lock[owner]) state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_STATE_RST;
            owner <= '0;
            rsp_q <= {NUM_REQ{RSP_VALID_RST}};
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            rsp_q <= grant;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr   <= ptr_nxt;
`endif
        end
    end

    assign rsp_valid = rsp_q;
    assign rsp_rdata = mem_read_data;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates a single-port synchronous RAM between `NUM_REQ` requesters (core load/store, loader/DMA, debug). Each requester has a valid/ready request channel and a one-cycle-latency response. Supports round-robin fairness and a lock so one requester can run atomic read-modify-write sequences. Sits directly in front of the data RAM; the same `rst` drives both.

## Interface
- `DATA_WIDTH`, default 32: data bus width.
- `MEM_DEPTH`, default 32: RAM words; `AW = $clog2(MEM_DEPTH)`.
- `NUM_REQ`, default 2: number of requesters, ≥2.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `req_valid` in, `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out, `NUM_REQ`: grant; at most one bit high per cycle.
- `req_we` in, `NUM_REQ`: 1 = write, 0 = read.
- `req_lock` in, `NUM_REQ`: keep ownership after this transfer.
- `req_addr` in, `NUM_REQ*AW`: flattened addresses; requester i occupies bits `[i*AW +: AW]`.
- `req_wdata` in, `NUM_REQ*DATA_WIDTH`: flattened write data.
- `rsp_valid` out, `NUM_REQ`: one-hot response strobe.
- `rsp_rdata` out, `DATA_WIDTH`: read data, shared bus, qualified by `rsp_valid`.
- `mem_we` out, 1: RAM write enable.
- `mem_address` out, `AW`: RAM address.
- `mem_write_data` out, `DATA_WIDTH`: RAM write data.
- `mem_read_data` in, `DATA_WIDTH`: RAM registered read output.

## Operation
- A transfer occurs on a rising edge when `req_valid[i] & req_ready[i]`.
- The `mem_*` outputs are combinational from the granted requester's fields. The RAM samples them on that same edge.
- With no grant: `mem_we`=0, `mem_address`=0, `mem_write_data`=0.
- Grant logic is combinational from `req_valid`, the priority state and the lock state. Ready never asserts without valid.

FSM `UNLOCKED` / `LOCKED(owner)`:
- **UNLOCKED:** pick among valid requesters using the priority policy (see Configuration).
  - Transfer with `req_lock`=1 moves to LOCKED, owner = granted index.
- **LOCKED:** only the owner can be granted; all other requesters see ready=0.
  - Owner transfer with `req_lock`=0 returns to UNLOCKED after that edge.
  - Owner deasserting valid keeps the lock; no timeout.

Responses:
- Every transfer, read or write, produces `rsp_valid[i]`=1 for exactly one cycle, the cycle after the transfer.
- Reads: `rsp_rdata` = `mem_read_data`, passed through.
- Writes: `rsp_rdata` is don't-care; tests check it only on reads.

Boundary cases:
- Back-to-back transfers, including same requester and same address, are allowed at one per cycle.
- Write then read of the same address on consecutive cycles returns the new data.

## Timing
- Request→RAM access: same edge (0 added cycles).
- Response latency: `rsp_valid` high exactly 1 cycle after the transfer edge.
- Throughput: 1 transfer per cycle.
- Reset values: `rsp_valid`=0, FSM=UNLOCKED, round-robin pointer=0. `req_ready` and `mem_*` follow from these combinationally.
- Reset mid-operation: a pending response is dropped and any lock is released. The RAM content is cleared by the same `rst`.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin. Search starts at the index after the last granted requester.
  - The pointer updates only on an UNLOCKED-state transfer.
- Undefined:
  - Fixed priority, lowest index wins. No pointer register.
- Lock behaviour is identical in both modes.

## Structure
- Package `ram_arb_pkg`:
  - `arb_state_t` enum {UNLOCKED, LOCKED}.
  - Reset constants.
  - `RAM_ARB_IDX_W(n)` helper for owner/pointer width.
- Sub-module `rr_picker`:
  - Parameterized one-hot selector.
  - Inputs: request vector, start pointer. Output: one-hot grant.
  - With the macro off, start is tied to 0, which gives fixed priority.

## Test plan
1. Reset, then req0 writes `0xDEADBEEF` to addr 5, then req0 reads addr 5 → `rsp_valid`=`01` one cycle after each transfer; read returns `0xDEADBEEF`.
2. Both requesters valid continuously, reading addrs 1/2, with round-robin on → grants alternate 0,1,0,1. With the macro off → req0 is granted every cycle and req1 is starved.
3. req1 issues a locked read of addr 3 (`req_lock`=1) while req0 is valid → req0 ready=0 until req1 writes addr 3 with `req_lock`=0. req0 is granted on the next cycle.
4. Lock owner drops valid for 4 cycles while req0 is valid → no grants for those 4 cycles; the lock is held.
5. Write `0x12` to addr 31, then immediately read addr 31 → read response `0x12`. Also check addr wrap: `MEM_DEPTH`=32 uses `AW`=5.
6. Assert `rst` in the cycle after a read transfer, while locked → `rsp_valid` stays 0, state is UNLOCKED, and the next grant goes to req0.
